// File: rtl/bp_cfg_param_responder_if.sv
// Request/response handshake bundle for bp_cfg_param_responder.
// Master issues field reads; slave answers with registered beats.
interface bp_cfg_param_if #(
  parameter int data_width_p = 64,
  parameter int addr_width_p = 8
) ();

  logic req_v_i;
  logic req_ready_o;
  logic [addr_width_p-1:0] req_addr_i;
  logic req_dump_i;
  logic resp_v_o;
  logic resp_ready_i;
  logic [addr_width_p-1:0] resp_addr_o;
  logic [data_width_p-1:0] resp_data_o;
  logic resp_err_o;
  logic resp_last_o;

  modport master (
    output req_v_i, req_addr_i, req_dump_i, resp_ready_i,
    input  req_ready_o, resp_v_o, resp_addr_o,
    input  resp_data_o, resp_err_o, resp_last_o
  );

  modport slave (
    input  req_v_i, req_addr_i, req_dump_i, resp_ready_i,
    output req_ready_o, resp_v_o, resp_addr_o,
    output resp_data_o, resp_err_o, resp_last_o
  );

endinterface

// File: rtl/bp_cfg_param_responder.sv
// Read-only responder returning numeric fields of the selected processor config.
// Burst dump of every field is built only when BP_CFG_RESP_DUMP_EN is defined.
package bp_cfg_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg     = 2'd0,
    e_bp_half_core_cfg   = 2'd1,
    e_bp_single_core_cfg = 2'd2,
    e_bp_dual_core_cfg   = 2'd3
  } bp_params_e;

  localparam int num_fields_gp = 39;

  typedef struct packed {
    logic [31:0] cc_x_dim;
    logic [31:0] cc_y_dim;
    logic [31:0] ic_y_dim;
    logic [31:0] mc_y_dim;
    logic [31:0] sac_x_dim;
    logic [31:0] vaddr_width;
    logic [31:0] paddr_width;
    logic [31:0] asid_width;
    logic [31:0] branch_metadata_fwd_width;
    logic [31:0] btb_tag_width;
    logic [31:0] btb_idx_width;
    logic [31:0] bht_idx_width;
    logic [31:0] ghist_width;
    logic [31:0] itlb_els;
    logic [31:0] dtlb_els;
    logic [31:0] lce_sets;
    logic [31:0] lce_assoc;
    logic [31:0] cce_block_width;
    logic [31:0] num_cce_instr_ram_els;
    logic [31:0] l2_sets;
    logic [31:0] l2_assoc;
    logic [31:0] l2_outstanding_reqs;
    logic [31:0] fe_queue_fifo_els;
    logic [31:0] fe_cmd_fifo_els;
    logic [31:0] async_coh_clk;
    logic [31:0] coh_noc_max_credits;
    logic [31:0] coh_noc_flit_width;
    logic [31:0] coh_noc_cid_width;
    logic [31:0] coh_noc_len_width;
    logic [31:0] async_mem_clk;
    logic [31:0] mem_noc_max_credits;
    logic [31:0] mem_noc_flit_width;
    logic [31:0] mem_noc_cid_width;
    logic [31:0] mem_noc_len_width;
    logic [31:0] async_io_clk;
    logic [31:0] io_noc_max_credits;
    logic [31:0] io_noc_flit_width;
    logic [31:0] io_noc_did_width;
    logic [31:0] io_noc_len_width;
  } bp_proc_param_s;

  function automatic bp_proc_param_s mk_cfg(
    input logic [31:0] x_dim,
    input logic [31:0] sets,
    input logic [31:0] assoc,
    input logic [31:0] blk
  );
    bp_proc_param_s c;
    c = '0;
    c.cc_x_dim = x_dim;
    c.cc_y_dim = 32'd1;
    c.ic_y_dim = 32'd1;
    c.vaddr_width = 32'd39;
    c.paddr_width = 32'd40;
    c.asid_width = 32'd1;
    c.branch_metadata_fwd_width = 32'd36;
    c.btb_tag_width = 32'd10;
    c.btb_idx_width = 32'd6;
    c.bht_idx_width = 32'd9;
    c.ghist_width = 32'd2;
    c.itlb_els = 32'd8;
    c.dtlb_els = 32'd8;
    c.lce_sets = sets;
    c.lce_assoc = assoc;
    c.cce_block_width = blk;
    c.num_cce_instr_ram_els = 32'd256;
    c.l2_sets = 32'd128;
    c.l2_assoc = 32'd8;
    c.l2_outstanding_reqs = 32'd2;
    c.fe_queue_fifo_els = 32'd8;
    c.fe_cmd_fifo_els = 32'd4;
    c.coh_noc_max_credits = 32'd8;
    c.coh_noc_flit_width = 32'd128;
    c.coh_noc_cid_width = 32'd2;
    c.coh_noc_len_width = 32'd3;
    c.mem_noc_max_credits = 32'd8;
    c.mem_noc_flit_width = 32'd64;
    c.mem_noc_cid_width = 32'd2;
    c.mem_noc_len_width = 32'd4;
    c.io_noc_max_credits = 32'd16;
    c.io_noc_flit_width = 32'd64;
    c.io_noc_did_width = 32'd3;
    c.io_noc_len_width = 32'd4;
    return c;
  endfunction

  localparam bp_proc_param_s [3:0] all_cfgs_gp = {
    mk_cfg(32'd2, 32'd64, 32'd4, 32'd512),
    mk_cfg(32'd1, 32'd128, 32'd8, 32'd256),
    mk_cfg(32'd1, 32'd64, 32'd4, 32'd256),
    mk_cfg(32'd1, 32'd64, 32'd8, 32'd512)
  };

endpackage

module bp_cfg_param_responder
  import bp_cfg_pkg::*;
#(
  parameter bp_params_e cfg_p = e_bp_single_core_cfg,
  parameter int data_width_p = 64,
  parameter int addr_width_p = 8
) (
  input  logic clk_i,
  input  logic reset_n_i,
  bp_cfg_param_if.slave bus
);

  localparam bp_proc_param_s cfg_cp = all_cfgs_gp[cfg_p];
  localparam logic [num_fields_gp-1:0][31:0] fields_cp = cfg_cp;
  localparam logic [5:0] last_idx_lp = 6'(num_fields_gp - 1);

`ifdef BP_CFG_RESP_DUMP_EN
  typedef enum logic [1:0] {IDLE, SINGLE, DUMP} state_e;
  logic [5:0] cnt_q, cnt_n;
`else
  typedef enum logic [1:0] {IDLE, SINGLE} state_e;
  logic dump_unused;
  assign dump_unused = bus.req_dump_i;
`endif

  state_e state_q, state_n;
  logic v_q, v_n;
  logic err_q, err_n;
  logic last_q, last_n;
  logic [addr_width_p-1:0] addr_q, addr_n;
  logic [data_width_p-1:0] data_q, data_n;

  logic [addr_width_p-1:0] look_idx;
  logic [data_width_p-1:0] look_data;
  logic look_err;
  logic req_ready, req_hs, resp_hs;

  assign req_ready = (state_q == IDLE);
  assign req_hs = bus.req_v_i & req_ready;
  assign resp_hs = v_q & bus.resp_ready_i;

  assign bus.req_ready_o = req_ready;
  assign bus.resp_v_o = v_q;
  assign bus.resp_addr_o = addr_q;
  assign bus.resp_data_o = data_q;
  assign bus.resp_err_o = err_q;
  assign bus.resp_last_o = last_q;

  // Index the next beat ahead of time so each beat leaves a register.
  always_comb begin
    look_idx = bus.req_addr_i;
`ifdef BP_CFG_RESP_DUMP_EN
    if (state_q == DUMP)
      look_idx = addr_width_p'(cnt_q + 6'd1);
    else if (bus.req_dump_i)
      look_idx = '0;
`endif
  end

  always_comb begin
    look_err = 1'b0;
    look_data = '0;
    if (int'(look_idx) < num_fields_gp)
      look_data = data_width_p'(
        fields_cp[last_idx_lp - 6'(look_idx)]);
    else if (int'(look_idx) == 255)
      look_data = data_width_p'(cfg_p);
    else
      look_err = 1'b1;
  end

  always_comb begin
    state_n = state_q;
    v_n = v_q;
    err_n = err_q;
    last_n = last_q;
    addr_n = addr_q;
    data_n = data_q;
`ifdef BP_CFG_RESP_DUMP_EN
    cnt_n = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_hs) begin
          state_n = SINGLE;
          v_n = 1'b1;
          addr_n = look_idx;
          data_n = look_data;
          err_n = look_err;
          last_n = 1'b1;
`ifdef BP_CFG_RESP_DUMP_EN
          if (bus.req_dump_i) begin
            state_n = DUMP;
            cnt_n = '0;
            err_n = 1'b0;
            last_n = 1'b0;
          end
`endif
        end
      end
      SINGLE: begin
        if (resp_hs) begin
          state_n = IDLE;
          v_n = 1'b0;
          err_n = 1'b0;
          last_n = 1'b0;
          addr_n = '0;
          data_n = '0;
        end
      end
`ifdef BP_CFG_RESP_DUMP_EN
      DUMP: begin
        if (resp_hs && cnt_q == last_idx_lp) begin
          state_n = IDLE;
          cnt_n = '0;
          v_n = 1'b0;
          last_n = 1'b0;
          addr_n = '0;
          data_n = '0;
        end else if (resp_hs) begin
          cnt_n = cnt_q + 6'd1;
          addr_n = look_idx;
          data_n = look_data;
          last_n = (cnt_q + 6'd1 == last_idx_lp);
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      v_q <= 1'b0;
      err_q <= 1'b0;
      last_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
`ifdef BP_CFG_RESP_DUMP_EN
      cnt_q <= '0;
`endif
    end else begin
      state_q <= state_n;
      v_q <= v_n;
      err_q <= err_n;
      last_q <= last_n;
      addr_q <= addr_n;
      data_q <= data_n;
`ifdef BP_CFG_RESP_DUMP_EN
      cnt_q <= cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_bp_cfg_param_responder.sv
// Scoreboard bench for bp_cfg_param_responder: queued expectations,
// independent monitor, randomized reads and dumps against a field model.
module tb_bp_cfg_param_responder;
  import bp_cfg_pkg::*;

  typedef struct packed {
    logic [7:0] addr;
    logic [63:0] data;
    logic err;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int rdy_mode = 1;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  bp_cfg_param_if #(.data_width_p(64), .addr_width_p(8)) bus ();
  bp_cfg_param_if #(.data_width_p(64), .addr_width_p(8)) bus2 ();

  bp_cfg_param_responder #(
    .cfg_p(e_bp_single_core_cfg),
    .data_width_p(64),
    .addr_width_p(8)
  ) dut (
    .clk_i(clk),
    .reset_n_i(rst_n),
    .bus(bus.slave)
  );

  bp_cfg_param_responder #(
    .cfg_p(e_bp_dual_core_cfg),
    .data_width_p(64),
    .addr_width_p(8)
  ) dut2 (
    .clk_i(clk),
    .reset_n_i(rst_n),
    .bus(bus2.slave)
  );

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, want);
    end
  endtask

  // Field i of a config is the i-th 32-bit member in declaration order.
  function automatic exp_t model(input int cfg, input int idx,
                                 input logic last);
    logic [num_fields_gp*32-1:0] flat;
    exp_t e;
    flat = all_cfgs_gp[2'(cfg)];
    e.addr = 8'(idx);
    e.data = '0;
    e.err = 1'b0;
    e.last = last;
    if (idx >= 0 && idx < num_fields_gp)
      e.data = 64'(flat[(num_fields_gp - 1 - idx) * 32 +: 32]);
    else if (idx == 255)
      e.data = 64'(cfg);
    else
      e.err = 1'b1;
    return e;
  endfunction

  task automatic push(input logic [7:0] a, input logic [63:0] d,
                      input logic er, input logic l);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.err = er;
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic push_dump();
    for (int i = 0; i < num_fields_gp - 1; i++)
      exp_q.push_back(model(2, i, 1'b0));
    push(8'd38, 64'd4, 1'b0, 1'b1);
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0)
      bus.resp_ready_i = ($urandom_range(0, 2) != 0);
    else
      bus.resp_ready_i = (rdy_mode == 1);
  end

  // Monitor: pops one expectation per response handshake.
  logic stall = 1'b0;
  logic [7:0] p_addr;
  logic [63:0] p_data;
  logic p_last;
  exp_t mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("stall_valid", 64'(bus.resp_v_o), 64'd1);
        check("stall_addr", 64'(bus.resp_addr_o), 64'(p_addr));
        check("stall_data", bus.resp_data_o, p_data);
        check("stall_last", 64'(bus.resp_last_o), 64'(p_last));
      end
      if (bus.resp_v_o)
        check("busy_req_ready", 64'(bus.req_ready_o), 64'd0);
      if (bus.resp_v_o && bus.resp_ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_beat: got addr 0x%0h with no beat required",
                   bus.resp_addr_o);
        end else begin
          mon_e = exp_q.pop_front();
          check("resp_addr", 64'(bus.resp_addr_o), 64'(mon_e.addr));
          check("resp_data", bus.resp_data_o, mon_e.data);
          check("resp_err", 64'(bus.resp_err_o), 64'(mon_e.err));
          check("resp_last", 64'(bus.resp_last_o), 64'(mon_e.last));
        end
      end
      stall = bus.resp_v_o && !bus.resp_ready_i;
      p_addr = bus.resp_addr_o;
      p_data = bus.resp_data_o;
      p_last = bus.resp_last_o;
    end
  end

  task automatic issue(input logic [7:0] a, input logic d);
    int n;
    @(posedge clk);
    #1;
    bus.req_v_i = 1'b1;
    bus.req_addr_i = a;
    bus.req_dump_i = d;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready_o && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: req_ready got 0 required 1");
    end
    @(posedge clk);
    #1;
    bus.req_v_i = 1'b0;
    bus.req_dump_i = 1'b0;
    bus.req_addr_i = 8'($urandom);
    @(negedge clk);
    check("latency_resp_v", 64'(bus.resp_v_o), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check("idle_after_drain", 64'(bus.resp_v_o), 64'd0);
  endtask

  task automatic rd2(input logic [7:0] a, input logic [63:0] want);
    int n;
    @(posedge clk);
    #1;
    bus2.req_v_i = 1'b1;
    bus2.req_addr_i = a;
    n = 0;
    @(negedge clk);
    while (!bus2.req_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("dual_accept", 64'(bus2.req_ready_o), 64'd1);
    @(posedge clk);
    #1;
    bus2.req_v_i = 1'b0;
    @(negedge clk);
    check("dual_resp_v", 64'(bus2.resp_v_o), 64'd1);
    check("dual_data", bus2.resp_data_o, want);
    check("dual_err", 64'(bus2.resp_err_o), 64'd0);
    @(posedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    int idx;
    logic d;
    bus.req_v_i = 1'b0;
    bus.req_addr_i = '0;
    bus.req_dump_i = 1'b0;
    bus.resp_ready_i = 1'b1;
    bus2.req_v_i = 1'b0;
    bus2.req_addr_i = '0;
    bus2.req_dump_i = 1'b0;
    bus2.resp_ready_i = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_resp_v", 64'(bus.resp_v_o), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
    check("rst_err", 64'(bus.resp_err_o), 64'd0);
    check("rst_last", 64'(bus.resp_last_o), 64'd0);
    check("rst_addr", 64'(bus.resp_addr_o), 64'd0);
    check("rst_data", bus.resp_data_o, 64'd0);

    push(8'd15, 64'd128, 1'b0, 1'b1);
    issue(8'd15, 1'b0);
    push(8'd17, 64'd256, 1'b0, 1'b1);
    issue(8'd17, 1'b0);
    push(8'hFF, 64'd2, 1'b0, 1'b1);
    issue(8'hFF, 1'b0);
    push(8'h40, 64'd0, 1'b1, 1'b1);
    issue(8'h40, 1'b0);
    drain();

`ifdef BP_CFG_RESP_DUMP_EN
    rdy_mode = 0;
    push_dump();
    issue(8'h40, 1'b1);
    drain();

    rdy_mode = 1;
    push_dump();
    issue(8'd3, 1'b1);
    repeat (11) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
`else
    rdy_mode = 2;
    exp_q.push_back(model(2, 7, 1'b1));
    issue(8'd7, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    rdy_mode = 1;
`endif
    @(negedge clk);
    check("mid_rst_resp_v", 64'(bus.resp_v_o), 64'd0);
    check("mid_rst_req_ready", 64'(bus.req_ready_o), 64'd1);
    push(8'd5, 64'd39, 1'b0, 1'b1);
    issue(8'd5, 1'b0);
    drain();

`ifndef BP_CFG_RESP_DUMP_EN
    push(8'd6, 64'd40, 1'b0, 1'b1);
    issue(8'd6, 1'b1);
    drain();
`endif

    rdy_mode = 0;
    repeat (40) begin
      idx = int'($urandom_range(0, 9));
      if (idx < 7)
        idx = int'($urandom_range(0, 38));
      else if (idx == 7)
        idx = 255;
      else
        idx = int'($urandom_range(39, 254));
      d = ($urandom_range(0, 5) == 0);
`ifdef BP_CFG_RESP_DUMP_EN
      if (d)
        push_dump();
      else
        exp_q.push_back(model(2, idx, 1'b1));
`else
      exp_q.push_back(model(2, idx, 1'b1));
`endif
      issue(8'(idx), d);
    end
    drain();
    rdy_mode = 1;

    rd2(8'd0, 64'd2);
    rd2(8'd15, 64'd64);
    rd2(8'd16, 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bp_cfg_param_responder.md
# bp_cfg_param_responder

Read-only responder for the processor configuration. It answers indexed read requests with individual numeric fields of the `bp_proc_param_s` selected by `cfg_p`, taken from `all_cfgs_gp`. It can also stream every field in order as a burst. It sits beside the config bus so that software and test harnesses can discover the built topology and cache geometry at runtime instead of hard-coding them.

## Interface
- `cfg_p`, default `e_bp_single_core_cfg`: `bp_params_e` index into `all_cfgs_gp`.
- `data_width_p`, default 64: response data width. Fields are zero-extended to this width.
- `addr_width_p`, default 8: field index width.

Ports:
- `clk_i`  in  1  clock.
- `reset_n_i`  in  1  reset, synchronous, active-low. One clock; reset is synchronous and active-low.
- `req_v_i`  in  1  request valid.
- `req_ready_o`  out  1  request ready.
- `req_addr_i`  in  `addr_width_p`  field index. Ignored when `req_dump_i` is 1.
- `req_dump_i`  in  1  when 1, stream all fields.
- `resp_v_o`  out  1  response valid.
- `resp_ready_i`  in  1  response ready.
- `resp_addr_o`  out  `addr_width_p`  index of the field being returned.
- `resp_data_o`  out  `data_width_p`  field value.
- `resp_err_o`  out  1  index not mapped. When set, `resp_data_o` is 0.
- `resp_last_o`  out  1  final beat of a transaction (always 1 for single reads).

## Operation
- Field map:
  - Index 0–38 follows the `bp_proc_param_s` declaration order. Anchors: 0 `cc_x_dim`, 5 `vaddr_width`, 15 `lce_sets`, 17 `cce_block_width`, 19 `l2_sets`, 38 `io_noc_len_width`.
  - Index 0xFF returns `cfg_p`.
  - Any other index returns `resp_err_o`=1 with data 0.
- Request handshake: a request is accepted when `req_v_i & req_ready_o`.
- FSM states: IDLE, SINGLE, DUMP.
- IDLE:
  - `req_ready_o`=1.
  - Accept with `req_dump_i`=0 → latch the index, go to SINGLE.
  - Accept with `req_dump_i`=1 → load the beat counter with 0, go to DUMP.
- SINGLE:
  - `resp_v_o`=1 with the latched index, its data, and `resp_last_o`=1.
  - On `resp_v_o & resp_ready_i`, go to IDLE.
- DUMP:
  - `resp_v_o`=1 with `resp_addr_o` equal to the counter and the matching data.
  - On each handshake the counter increments.
  - `resp_last_o`=1 when the counter is 38. The handshake on that beat returns to IDLE and clears the counter.
  - The counter is 6 bits and never wraps past 38.
- `req_ready_o`=0 in SINGLE and DUMP. Requests presented there are held off, not dropped.
- Response outputs are registered and held stable while `resp_v_o & ~resp_ready_i`.
- `resp_err_o` is never set during a dump.

## Timing
- Reset (`reset_n_i`=0 at a clock edge):
  - State becomes IDLE.
  - `req_ready_o`=1.
  - `resp_v_o`, `resp_err_o` and `resp_last_o` are 0.
  - `resp_addr_o` and `resp_data_o` are 0.
- Reset mid-transaction, whether in SINGLE or DUMP: the transaction is abandoned. The cycle after reset shows `resp_v_o`=0 and `req_ready_o`=1, and no partial beat is replayed.
- Latency: request accepted at edge N → `resp_v_o`=1 during the cycle after edge N.
- Throughput:
  - Single reads: one every 2 cycles at best. `req_ready_o` rises the cycle after the final response handshake; there is no same-cycle re-accept.
  - Dump: one beat per cycle with `resp_ready_i` held high, so 39 cycles from first beat to last.
- Backpressure: `resp_ready_i` may deassert on any cycle. Data, address and last stay unchanged until the handshake.
- A new request presented in the same cycle as the final response handshake is not accepted. It is accepted on the next cycle.

## Configuration
- Macro: `BP_CFG_RESP_DUMP_EN`.
- Defined: DUMP state and the beat counter are present, and streaming behaves as above.
- Undefined:
  - DUMP and the counter are removed.
  - `req_dump_i` is ignored, so every request is a single read of `req_addr_i`.
  - `resp_last_o` is always 1 when `resp_v_o` is 1.

## Test plan
- Single read, `cfg_p`=`e_bp_single_core_cfg`: read idx 15 → data 128; idx 17 → 256; idx 0xFF → 2. In each case `resp_err_o`=0, `resp_last_o`=1, and `resp_v_o` is seen 1 cycle after acceptance.
- Unmapped read: idx 0x40 → `resp_err_o`=1, data 0, `resp_addr_o`=0x40.
- `cfg_p`=`e_bp_dual_core_cfg`: idx 0 → 2; idx 15 → 64; idx 16 → 4.
- Dump with `resp_ready_i` randomly toggled: exactly 39 beats with addr 0..38 in order. `resp_last_o` appears only on addr 38 with data 4. Outputs stay stable while stalled. `req_ready_o`=0 throughout.
- Reset mid-dump, asserted after beat 10: the next cycle shows `resp_v_o`=0 and `req_ready_o`=1. A fresh single read of idx 5 then returns 39.
- Macro undefined: request with `req_dump_i`=1 and addr 6 → one beat, data 40, `resp_last_o`=1.
